// File: rtl/reg_bank_pkg.sv
// Shared constants and strobe-decode types for the register bank.
package reg_bank_pkg;

  localparam int unsigned WIDTH    = 16;
  localparam int unsigned NUM_REGS = 8;
  localparam int unsigned PC_INDEX = 7;

  typedef enum logic [1:0] {
    STROBE_IDLE,
    STROBE_SELECT,
    STROBE_CONFLICT
  } strobeKind_t;

  typedef struct packed {
    strobeKind_t kind;
    logic [2:0]  index;
  } strobeDecode_t;

  function automatic strobeDecode_t classifyStrobe(input logic valid, input logic multi,
                                                   input logic [2:0] index);
    strobeDecode_t d;
    d.index = index;
    if (multi)      d.kind = STROBE_CONFLICT;
    else if (valid) d.kind = STROBE_SELECT;
    else            d.kind = STROBE_IDLE;
    return d;
  endfunction

endpackage

// File: rtl/onehot_n_decode.sv
// Decodes an 8-bit active-low strobe vector into index / single-select / multi-select.
module onehot_n_decode (
  input  logic [7:0] strobesN,
  output logic [2:0] index,
  output logic       valid,
  output logic       multi
);

  logic [3:0] zeroCount;

  always_comb begin
    zeroCount = '0;
    index     = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (!strobesN[i]) begin
        zeroCount = zeroCount + 4'd1;
        index     = 3'(i);
      end
    end
    valid = (zeroCount == 4'd1);
    multi = (zeroCount > 4'd1);
  end

endmodule

// File: rtl/reg_bank.sv
// Eight-entry register bank with strobe-addressed load/read, a PC increment
// register and sticky strobe-conflict flags.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int unsigned WIDTH    = reg_bank_pkg::WIDTH,
  parameter int unsigned NUM_REGS = reg_bank_pkg::NUM_REGS,
  parameter int unsigned PC_INDEX = reg_bank_pkg::PC_INDEX
) (
  input  logic             clock,
  input  logic             notReset,
  input  logic [7:0]       regNotOEs,
  input  logic [7:0]       regNotLoads,
  input  logic [WIDTH-1:0] dataIn,
  input  logic             pcInc,
  input  logic             errClear,
  output logic [WIDTH-1:0] dataOut,
  output logic             dataOutValid,
  output logic             oeContentionErr,
  output logic             loadConflictErr
);

  localparam logic [2:0] PC_SEL = 3'(PC_INDEX);

  logic [WIDTH-1:0] regs [NUM_REGS];

  logic [2:0]    oeIndex, loadIndex;
  logic          oeValid, oeMulti, loadValid, loadMulti;
  strobeDecode_t oeDec, loadDec;
  logic          loadHitsPc;

  onehot_n_decode oeDecode (
    .strobesN (regNotOEs),
    .index    (oeIndex),
    .valid    (oeValid),
    .multi    (oeMulti)
  );

  onehot_n_decode loadDecode (
    .strobesN (regNotLoads),
    .index    (loadIndex),
    .valid    (loadValid),
    .multi    (loadMulti)
  );

  assign oeDec      = classifyStrobe(oeValid, oeMulti, oeIndex);
  assign loadDec    = classifyStrobe(loadValid, loadMulti, loadIndex);
  assign loadHitsPc = (loadDec.kind == STROBE_SELECT) && (loadDec.index == PC_SEL);

  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (loadDec.kind == STROBE_SELECT) regs[loadDec.index] <= dataIn;
      // A load to the PC register overrides the increment; a conflicting load does not.
      if (pcInc && !loadHitsPc) regs[PC_INDEX] <= regs[PC_INDEX] + WIDTH'(1);
    end
  end

  // Flags: a new conflict in the same cycle as errClear keeps the flag set.
  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      oeContentionErr <= 1'b0;
      loadConflictErr <= 1'b0;
    end else begin
      if (oeDec.kind == STROBE_CONFLICT) oeContentionErr <= 1'b1;
      else if (errClear)                 oeContentionErr <= 1'b0;
      if (loadDec.kind == STROBE_CONFLICT) loadConflictErr <= 1'b1;
      else if (errClear)                   loadConflictErr <= 1'b0;
    end
  end

  always_comb begin
    dataOut      = '0;
    dataOutValid = 1'b0;
    if (oeDec.kind == STROBE_SELECT) begin
      dataOut      = regs[oeDec.index];
      dataOutValid = 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_bank.sv
// Directed bench for reg_bank: stimulus queues expected outputs, a negedge
// monitor pops and compares them.
module tb_reg_bank;

  logic        clock;
  logic        notReset;
  logic [7:0]  regNotOEs;
  logic [7:0]  regNotLoads;
  logic [15:0] dataIn;
  logic        pcInc;
  logic        errClear;
  logic [15:0] dataOut;
  logic        dataOutValid;
  logic        oeContentionErr;
  logic        loadConflictErr;

  typedef struct packed {
    logic [15:0] data;
    logic        valid;
    logic        oeErr;
    logic        ldErr;
  } exp_t;

  exp_t  expQ [$];
  string nameQ [$];
  int    checks = 0;
  int    passes = 0;

  reg_bank #(.WIDTH(16), .NUM_REGS(8), .PC_INDEX(7)) dut (
    .clock           (clock),
    .notReset        (notReset),
    .regNotOEs       (regNotOEs),
    .regNotLoads     (regNotLoads),
    .dataIn          (dataIn),
    .pcInc           (pcInc),
    .errClear        (errClear),
    .dataOut         (dataOut),
    .dataOutValid    (dataOutValid),
    .oeContentionErr (oeContentionErr),
    .loadConflictErr (loadConflictErr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (expQ.size() > 0) begin
      exp_t  e;
      string n;
      e = expQ.pop_front();
      n = nameQ.pop_front();
      checks++;
      if (dataOut === e.data) passes++;
      else $display("FAIL %s dataOut got %h want %h", n, dataOut, e.data);
      checks++;
      if (dataOutValid === e.valid) passes++;
      else $display("FAIL %s dataOutValid got %b want %b", n, dataOutValid, e.valid);
      checks++;
      if (oeContentionErr === e.oeErr) passes++;
      else $display("FAIL %s oeContentionErr got %b want %b", n, oeContentionErr, e.oeErr);
      checks++;
      if (loadConflictErr === e.ldErr) passes++;
      else $display("FAIL %s loadConflictErr got %b want %b", n, loadConflictErr, e.ldErr);
    end
  end

  task automatic drive(input logic [7:0] oes, input logic [7:0] lds, input logic [15:0] din,
                       input logic inc, input logic clr);
    regNotOEs   = oes;
    regNotLoads = lds;
    dataIn      = din;
    pcInc       = inc;
    errClear    = clr;
  endtask

  task automatic expect_now(input string n, input logic [15:0] d, input logic v,
                            input logic oe, input logic ld);
    exp_t e;
    e.data  = d;
    e.valid = v;
    e.oeErr = oe;
    e.ldErr = ld;
    expQ.push_back(e);
    nameQ.push_back(n);
  endtask

  // One clock cycle: drive inputs, queue the outputs expected before the edge.
  task automatic cyc(input string n, input logic [7:0] oes, input logic [7:0] lds,
                     input logic [15:0] din, input logic inc, input logic clr,
                     input logic [15:0] d, input logic v, input logic oe, input logic ld);
    drive(oes, lds, din, inc, clr);
    expect_now(n, d, v, oe, ld);
    @(posedge clock);
    #1;
  endtask

  initial begin
    int waitCycles;
    notReset = 1'b0;
    drive(8'hFF, 8'hFF, 16'h0000, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    cyc("reset_read_r0", 8'hFE, 8'hFF, 16'h0000, 0, 0, 16'h0000, 1, 0, 0);
    notReset = 1'b1;

    cyc("idle_write_r3",   8'hFF, 8'hF7, 16'h1234, 0, 0, 16'h0000, 0, 0, 0);
    cyc("read_r3",         8'hF7, 8'hFF, 16'h0000, 0, 0, 16'h1234, 1, 0, 0);
    cyc("write_r2",        8'hFF, 8'hFB, 16'h2222, 0, 0, 16'h0000, 0, 0, 0);
    cyc("load_conflict",   8'hFF, 8'hF3, 16'hBEEF, 0, 0, 16'h0000, 0, 0, 0);
    cyc("r2_kept",         8'hFB, 8'hFF, 16'h0000, 0, 0, 16'h2222, 1, 0, 1);
    cyc("r3_kept_clr",     8'hF7, 8'hFF, 16'h0000, 0, 1, 16'h1234, 1, 0, 1);
    cyc("ld_err_cleared",  8'hFF, 8'hFF, 16'h0000, 0, 0, 16'h0000, 0, 0, 0);
    cyc("write_r7_ffff",   8'hFF, 8'h7F, 16'hFFFF, 0, 0, 16'h0000, 0, 0, 0);
    cyc("r7_inc_wrap",     8'h7F, 8'hFF, 16'h0000, 1, 0, 16'hFFFF, 1, 0, 0);
    cyc("r7_load_beats_inc", 8'h7F, 8'h7F, 16'h0100, 1, 0, 16'h0000, 1, 0, 0);
    cyc("r7_inc_and_load_r0", 8'h7F, 8'hFE, 16'h0A0A, 1, 0, 16'h0100, 1, 0, 0);
    cyc("r0_inc_in_conflict", 8'hFE, 8'h3F, 16'h9999, 1, 0, 16'h0A0A, 1, 0, 0);
    cyc("set_beats_clear", 8'h7F, 8'hFC, 16'h4444, 0, 1, 16'h0102, 1, 0, 1);
    cyc("r6_untouched_clr", 8'hBF, 8'hFF, 16'h0000, 0, 1, 16'h0000, 1, 0, 1);
    cyc("oe_conflict",     8'hFC, 8'hFF, 16'h0000, 0, 0, 16'h0000, 0, 0, 0);
    cyc("oe_err_set_idle", 8'hFF, 8'hFF, 16'h0000, 0, 0, 16'h0000, 0, 1, 0);
    cyc("r1_zero_clr",     8'hFD, 8'hFF, 16'h0000, 0, 1, 16'h0000, 1, 1, 0);
    cyc("rdw_r1_old",      8'hFD, 8'hFD, 16'h5555, 0, 0, 16'h0000, 1, 0, 0);
    cyc("rdw_r1_new",      8'hFD, 8'hFF, 16'h0000, 0, 0, 16'h5555, 1, 0, 0);
    cyc("write_r5",        8'hFF, 8'hDF, 16'hAAAA, 0, 0, 16'h0000, 0, 0, 0);
    cyc("both_conflicts",  8'hFC, 8'hFC, 16'h1111, 0, 0, 16'h0000, 0, 0, 0);
    cyc("r5_flags_set",    8'hDF, 8'hFF, 16'h0000, 0, 0, 16'hAAAA, 1, 1, 1);

    // Reset asserted between edges while r5 is being read.
    drive(8'hDF, 8'hFF, 16'h0000, 0, 0);
    expect_now("mid_cycle_reset", 16'h0000, 1, 0, 0);
    #3 notReset = 1'b0;
    @(posedge clock);
    #1;
    cyc("reset_blocks_write", 8'hEF, 8'hEF, 16'h7777, 1, 0, 16'h0000, 1, 0, 0);
    notReset = 1'b1;
    cyc("r4_not_written",  8'hEF, 8'hFF, 16'h0000, 0, 0, 16'h0000, 1, 0, 0);
    cyc("r7_no_inc_write_r4", 8'h7F, 8'hEF, 16'h7777, 0, 0, 16'h0000, 1, 0, 0);
    cyc("r4_after_release", 8'hEF, 8'hFF, 16'h0000, 0, 0, 16'h7777, 1, 0, 0);
    drive(8'hFF, 8'hFF, 16'h0000, 0, 0);

    waitCycles = 0;
    while (expQ.size() > 0 && waitCycles < 5) begin
      @(posedge clock);
      waitCycles++;
    end
    if (expQ.size() > 0) begin
      checks++;
      $display("FAIL drain pending=%0d want 0", expQ.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/reg_bank.md
REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 Parameter WIDTH, default 16: data width of each register and of both data buses.
REQ-002 Parameter NUM_REGS, default 8: number of registers; fixed at 8 to match the 8-bit strobe vectors.
REQ-003 Parameter PC_INDEX, default 7: index of the register that supports increment.
REQ-004 The block SHALL have exactly one clock and an asynchronous, active-low reset.
REQ-005 clock  input  1  rising-edge clock for all state.
REQ-006 notReset  input  1  asynchronous active-low reset.
REQ-007 regNotOEs  input  8  active-low one-hot output-enable strobes; bit i selects register i.
REQ-008 regNotLoads  input  8  active-low one-hot load strobes; bit i selects register i.
REQ-009 dataIn  input  WIDTH  write data.
REQ-010 pcInc  input  1  increments register PC_INDEX at the clock edge.
REQ-011 errClear  input  1  synchronous clear of the sticky error flags.
REQ-012 dataOut  output  WIDTH  contents of the selected register.
REQ-013 dataOutValid  output  1  high when exactly one OE strobe is low.
REQ-014 oeContentionErr  output  1  sticky flag: more than one OE strobe was low at a clock edge.
REQ-015 loadConflictErr  output  1  sticky flag: more than one load strobe was low at a clock edge.

Function
REQ-016 Strobe decode: all ones means idle; exactly one zero means select index i; two or more zeros means a conflict.
REQ-017 Read path is combinational:
- one OE low: dataOut = reg[i] and dataOutValid = 1;
- otherwise: dataOut = 0 and dataOutValid = 0.
REQ-018 Write: at a rising edge with exactly one load strobe low, reg[i] <= dataIn; the write is visible on dataOut from the next cycle.
REQ-019 Read-during-write of the same register: dataOut shows the old value during that cycle and the new value after the edge.
REQ-020 Load conflict: at a rising edge with two or more load strobes low, no register is written and loadConflictErr is set to 1.
REQ-021 OE conflict: at a rising edge with two or more OE strobes low, oeContentionErr is set to 1; register contents are unaffected.
REQ-022 pcInc = 1 with no load targeting PC_INDEX: reg[PC_INDEX] <= reg[PC_INDEX] + 1, modulo 2^WIDTH (0xFFFF wraps to 0x0000).
REQ-023 pcInc = 1 while the only low load strobe selects PC_INDEX: the load wins and the increment is discarded.
REQ-024 pcInc = 1 during a load conflict: the increment still occurs.
REQ-025 The error flags are sticky; errClear = 1 clears both at the next edge.
REQ-026 errClear = 1 in the same cycle as a new conflict: the flag is set (the set wins).
REQ-027 A load to a register other than PC_INDEX in the same cycle as pcInc: both take effect.

Reset
REQ-028 Asserting notReset low SHALL immediately clear all registers to 0 and both error flags to 0, independent of clock.
REQ-029 During reset, dataOut SHALL still follow REQ-017; with any single OE low it therefore reads 0.
REQ-030 Reset asserted mid-cycle SHALL discard any pending load or increment; the first write after release occurs at the first rising edge with notReset high.

Structure
REQ-031 A shared package reg_bank_pkg SHALL hold WIDTH, NUM_REGS, PC_INDEX and the strobe-decode result type (idle / select / conflict, plus the index).
REQ-032 One sub-module, onehot_n_decode, SHALL decode an 8-bit active-low strobe vector into index, valid and multi; reg_bank SHALL instantiate it twice (OE and load).
REQ-033 There SHALL be no tristate drivers; the output mux is internal.

Verification
REQ-034 Write 0x1234 to r3 (regNotLoads = 0xF7) -> next cycle, regNotOEs = 0xF7 gives dataOut = 0x1234 and dataOutValid = 1.
REQ-035 regNotLoads = 0xF3 with dataIn = 0xBEEF -> r2 and r3 unchanged and loadConflictErr = 1; errClear pulse -> flag returns to 0.
REQ-036 r7 = 0xFFFF, pcInc = 1 -> r7 = 0x0000; pcInc = 1 with a load of 0x0100 to r7 -> r7 = 0x0100.
REQ-037 regNotOEs = 0xFC -> dataOut = 0, dataOutValid = 0, oeContentionErr = 1 after the edge; regNotOEs = 0xFF -> dataOutValid = 0, no error.
REQ-038 Load r5 = 0xAAAA, assert notReset low between clock edges -> r5 reads 0 immediately and both flags read 0.
REQ-039 Read r1 while writing 0x5555 to r1 -> old value in that cycle, 0x5555 in the next cycle.
